// File: rtl/p2r_pkg.sv
// Shared types and constants for the polar-to-rectangular CORDIC converter.
package p2r_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESCALE = 2'd1,
        ITERATE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Gain-compensation constant K ~= 0.607422 = 2^-1 + 2^-3 - 2^-6 - 2^-9
    localparam int K_SH0 = 1;   // +
    localparam int K_SH1 = 3;   // +
    localparam int K_SH2 = 6;   // -
    localparam int K_SH3 = 9;   // -

    // Output saturation limits (symmetric, so negation never overflows)
    localparam int SAT_MAX = 255;
    localparam int SAT_MIN = -255;

    localparam int ATAN_N = 10;

    // atan(2^-i) in 4096-units-per-turn, 12-bit signed
    function automatic logic signed [11:0] atan_lut(input logic [3:0] idx);
        logic signed [11:0] v;
        case (idx)
            4'd0:    v = 12'sd512;
            4'd1:    v = 12'sd302;
            4'd2:    v = 12'sd160;
            4'd3:    v = 12'sd81;
            4'd4:    v = 12'sd41;
            4'd5:    v = 12'sd20;
            4'd6:    v = 12'sd10;
            4'd7:    v = 12'sd5;
            4'd8:    v = 12'sd3;
            4'd9:    v = 12'sd1;
            default: v = 12'sd0;
        endcase
        atan_lut = v;
    endfunction

endpackage

// File: rtl/p2r_if.sv
// Valid/ready request and response bundle for the polar-to-rectangular block.
interface p2r_if;
    logic              in_valid;
    logic              in_ready;
    logic        [7:0] mag;
    logic        [7:0] angle;
    logic              out_valid;
    logic              out_ready;
    logic signed [8:0] x_out;
    logic signed [8:0] y_out;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, mag, angle, out_ready,
        input  in_ready, out_valid, x_out, y_out
    );

    // Converter side
    modport slave (
        input  in_valid, mag, angle, out_ready,
        output in_ready, out_valid, x_out, y_out
    );
endinterface

// File: rtl/p2r_round_sat.sv
// Round-to-nearest and saturate a WIDTH/FRAC fixed-point value to signed 9-bit.
module p2r_round_sat
    import p2r_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 5
) (
    input  logic signed [WIDTH-1:0] din,
    output logic signed [8:0]       dout
);

    // One extra bit so adding the half-LSB bias can never wrap
    localparam logic signed [WIDTH:0] HALF   = (WIDTH+1)'(2 ** (FRAC - 1));
    localparam logic signed [WIDTH:0] SAT_HI = (WIDTH+1)'(SAT_MAX);
    localparam logic signed [WIDTH:0] SAT_LO = (WIDTH+1)'(SAT_MIN);

    logic signed [WIDTH:0] biased;
    logic signed [WIDTH:0] shifted;

    assign biased  = {din[WIDTH-1], din} + HALF;
    assign shifted = biased >>> FRAC;

    // Clamp the integer part to the symmetric +/-255 range
    always_comb begin
        dout = shifted[8:0];
        if (shifted > SAT_HI)
            dout = 9'(SAT_MAX);
        else if (shifted < SAT_LO)
            dout = 9'(SAT_MIN);
    end

endmodule

// File: rtl/tt_um_polar_rect.sv
// Polar-to-rectangular converter: iterative rotation-mode CORDIC, one
// conversion in flight, valid/ready on both sides.
// Build option: define P2R_GAIN_COMP_EN to prescale the magnitude by K so the
// outputs are true components; otherwise they carry the CORDIC gain (~1.6468).
module tt_um_polar_rect
    import p2r_pkg::*;
#(
    parameter int ITER  = 8,
    parameter int WIDTH = 16,
    parameter int FRAC  = 5
) (
    input  logic clk,
    input  logic rst,
    p2r_if.slave bus
);

    state_t state, state_n;

    logic                    in_ready_c;
    logic                    out_valid_c;
    logic                    accept;
    logic                    fold_cycle;

    logic              [1:0] q;
    logic signed      [11:0] z;
    logic signed [WIDTH-1:0] x, y;
    logic              [3:0] i;
    logic              [7:0] mag_q;
    logic signed       [8:0] x_reg, y_reg;

    logic signed [WIDTH-1:0] mag_fx;
    logic signed [WIDTH-1:0] x_init;
    logic signed [WIDTH-1:0] xs, ys;
    logic signed [WIDTH-1:0] x_n, y_n;
    logic signed      [11:0] z_n;
    logic signed      [11:0] atan_i;
    logic signed [WIDTH-1:0] fx, fy;
    logic signed       [8:0] x_res, y_res;

    // After ITER rotations the counter sits at ITER; that extra ITERATE cycle
    // folds the quadrant and registers the rounded result from settled x/y.
    assign fold_cycle = (i == 4'(ITER));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n     = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_n = PRESCALE;
                end
            end
            PRESCALE: state_n = ITERATE;
            ITERATE:  if (fold_cycle) state_n = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.x_out     = x_reg;
    assign bus.y_out     = y_reg;

    // Magnitude in fixed point, optionally prescaled by K via shift-add
    assign mag_fx = WIDTH'({mag_q, {FRAC{1'b0}}});
`ifdef P2R_GAIN_COMP_EN
    assign x_init = (mag_fx >>> K_SH0) + (mag_fx >>> K_SH1)
                  - (mag_fx >>> K_SH2) - (mag_fx >>> K_SH3);
`else
    assign x_init = mag_fx;
`endif

    // One micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        xs     = x >>> i;
        ys     = y >>> i;
        atan_i = atan_lut(i);
        if (!z[11]) begin
            x_n = x - ys;
            y_n = y + xs;
            z_n = z - atan_i;
        end else begin
            x_n = x + ys;
            y_n = y - xs;
            z_n = z + atan_i;
        end
    end

    // Quadrant fold back from the first-quadrant rotation
    always_comb begin
        case (q)
            2'd0:    begin fx = x;  fy = y;  end
            2'd1:    begin fx = -y; fy = x;  end
            2'd2:    begin fx = -x; fy = -y; end
            default: begin fx = y;  fy = -x; end
        endcase
    end

    p2r_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rs_x (.din(fx), .dout(x_res));
    p2r_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rs_y (.din(fy), .dout(y_res));

    // Datapath: capture request, prescale, rotate, then register result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            z     <= '0;
            x     <= '0;
            y     <= '0;
            i     <= '0;
            mag_q <= '0;
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q     <= bus.angle[7:6];
                        // One angle LSB is 16 units of the 4096-per-turn
                        // scale, so the in-quadrant part lands on bits [9:4]
                        // and stays positive (0..1008 < 90 deg = 1024).
                        z     <= {2'b00, bus.angle[5:0], 4'b0000};
                        mag_q <= bus.mag;
                    end
                end
                PRESCALE: begin
                    x <= x_init;
                    y <= '0;
                    i <= '0;
                end
                ITERATE: begin
                    if (fold_cycle) begin
                        x_reg <= x_res;
                        y_reg <= y_res;
                    end else begin
                        x <= x_n;
                        y <= y_n;
                        z <= z_n;
                        i <= i + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_polar_rect.sv
// Directed bench for tt_um_polar_rect (ITER=8, WIDTH=16, FRAC=5).
// Expected tables follow the P2R_GAIN_COMP_EN build option.
module tb_tt_um_polar_rect;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    p2r_if bus();

    tt_um_polar_rect #(.ITER(8), .WIDTH(16), .FRAC(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] mag;
        logic [7:0] ang;
        int         ex;
        int         ey;
        int         tol;
        bit         chk_y;
    } vec_t;

    vec_t tv[7];

`ifdef P2R_GAIN_COMP_EN
    localparam int X100 = 100;
`else
    localparam int X100 = 165;
`endif

    task automatic chk(input string name, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // Present one request at the negedge; returns just after the accepting edge
    task automatic start_conv(input logic [7:0] m, input logic [7:0] a, input logic rdy);
        @(negedge clk);
        chk("in_ready_idle", int'(bus.in_ready), 1, 0);
        bus.mag       = m;
        bus.angle     = a;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept until out_valid is seen (bounded)
    task automatic wait_valid(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = bus.out_valid;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout: got 0 after %0d edges want 1", lat);
        end
    endtask

    // Output handshake, then the block must be back in IDLE with no result
    task automatic finish_conv();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("done_exit_valid", int'(bus.out_valid), 0, 0);
        chk("done_exit_ready", int'(bus.in_ready), 1, 0);
    endtask

    initial begin
        int lat;

`ifdef P2R_GAIN_COMP_EN
        tv[0] = '{8'd200, 8'd0,   200,    0, 1, 1'b1};
        tv[1] = '{8'd200, 8'd64,    0,  200, 2, 1'b1};
        tv[2] = '{8'd100, 8'd128, -100,   0, 2, 1'b1};
        tv[3] = '{8'd200, 8'd32,  141,  141, 2, 1'b1};
        tv[4] = '{8'd200, 8'd224, 141, -141, 2, 1'b1};
        tv[5] = '{8'd200, 8'd192,   0, -200, 2, 1'b1};
        tv[6] = '{8'd0,   8'd77,    0,    0, 0, 1'b1};
`else
        tv[0] = '{8'd100, 8'd0,   165,    0, 2, 1'b1};
        tv[1] = '{8'd100, 8'd64,    0,  165, 2, 1'b1};
        tv[2] = '{8'd100, 8'd128, -165,   0, 2, 1'b1};
        tv[3] = '{8'd80,  8'd32,   93,   93, 2, 1'b1};
        tv[4] = '{8'd255, 8'd0,   255,    0, 0, 1'b0};
        tv[5] = '{8'd255, 8'd128, -255,   0, 0, 1'b0};
        tv[6] = '{8'd0,   8'd77,    0,    0, 0, 1'b1};
`endif

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mag       = 8'd0;
        bus.angle     = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0, 0);
        chk("rst_x_out", int'(bus.x_out), 0, 0);
        chk("rst_y_out", int'(bus.y_out), 0, 0);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", int'(bus.in_ready), 1, 0);

        // Table-driven conversions
        for (int k = 0; k < 7; k++) begin
            start_conv(tv[k].mag, tv[k].ang, 1'b0);
            wait_valid(lat);
            if (k == 0) chk("latency", lat, 10, 0);
            chk($sformatf("x[%0d]", k), int'(bus.x_out), tv[k].ex, tv[k].tol);
            if (tv[k].chk_y)
                chk($sformatf("y[%0d]", k), int'(bus.y_out), tv[k].ey, tv[k].tol);
            finish_conv();
        end

        // Backpressure: result held, input ignored while out_ready low
        start_conv(8'd100, 8'd0, 1'b0);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", int'(bus.out_valid), 1, 0);
            chk("hold_in_ready", int'(bus.in_ready), 0, 0);
            chk("hold_x", int'(bus.x_out), X100, 2);
            chk("hold_y", int'(bus.y_out), 0, 2);
            bus.mag      = 8'd7;
            bus.angle    = 8'd99;
            bus.in_valid = (c % 2 == 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        finish_conv();
        repeat (2) @(negedge clk);
        chk("no_second_accept", int'(bus.out_valid), 0, 0);
        chk("idle_after_hold", int'(bus.in_ready), 1, 0);

        // out_ready already high: DONE lasts exactly one cycle
        start_conv(8'd100, 8'd64, 1'b1);
        wait_valid(lat);
        chk("early_x", int'(bus.x_out), 0, 2);
        chk("early_y", int'(bus.y_out), X100, 2);
        @(negedge clk);
        chk("done_one_cycle", int'(bus.out_valid), 0, 0);
        bus.out_ready = 1'b0;

        // Reset in ITERATE cycle 3 clears outputs at once
        start_conv(8'd100, 8'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", int'(bus.out_valid), 0, 0);
        chk("abort_x", int'(bus.x_out), 0, 0);
        chk("abort_y", int'(bus.y_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Conversion after the abort is correct
        start_conv(8'd100, 8'd128, 1'b0);
        wait_valid(lat);
        chk("post_abort_lat", lat, 10, 0);
        chk("post_abort_x", int'(bus.x_out), -X100, 2);
        chk("post_abort_y", int'(bus.y_out), 0, 2);
        finish_conv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
